// File: rtl/sample2uart_tx.sv
// Serializes one BPS-bit sample as NBYTES back-to-back 8N1 frames, MSB byte first, LSB bit first.
// Start bit leaves one cycle after accept; new samples are accepted only on an enable edge while idle.
module sample2uart_tx #(
  parameter int BPS      = 24,
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic           in_clk,
  input  logic           in_rst,
  input  logic [BPS-1:0] in_sample,
  input  logic           in_sample_en,
  output logic           out_ready,
  output logic           out_tx,
  output logic           out_done
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int NBYTES       = (BPS + 7) / 8;
  localparam int W            = NBYTES * 8;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
  logic [W-1:0]      shift_q, shift_d;
  logic              en_q;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              accept, bit_end;
  logic [2:0]        bit_nxt;
  logic [7:0]        cur_byte;

  assign accept   = in_sample_en & ~en_q & (state_q == IDLE);
  assign bit_end  = (clk_cnt_q == CNT_LAST);
  assign bit_nxt  = bit_idx_q + 3'd1;
  // The byte on the wire always sits at the top; the register shifts up one byte per frame.
  assign cur_byte = shift_q[W-1 -: 8];

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    if (state_q != IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d    = START;
          clk_cnt_d  = '0;
          byte_idx_d = BYTE_W'(NBYTES - 1);
          shift_d    = W'(in_sample);
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_nxt;
            tx_d      = cur_byte[bit_nxt];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx_q != '0) begin
            state_d    = START;
            byte_idx_d = byte_idx_q - BYTE_W'(1);
            shift_d    = shift_q << 8;
            tx_d       = 1'b0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      en_q       <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      en_q       <= in_sample_en;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign out_ready = (state_q == IDLE);
  assign out_tx    = tx_q;
  assign out_done  = done_q;

endmodule

// File: tb/tb_sample2uart_tx.sv
// Bench for sample2uart_tx: a 24-bit and a 12-bit instance at 4 clocks per bit, checked cycle by cycle
// against an expected line waveform built from the frame format.
module tb_sample2uart_tx;
  localparam int CPB = 400 / 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s24;
  logic [11:0] s12;
  logic        en24, en12;
  logic        rdy24, tx24, done24;
  logic        rdy12, tx12, done12;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  sample2uart_tx #(.BPS(24), .CLK_FREQ(400), .BAUD(100)) dut (
    .in_clk(clk), .in_rst(rst), .in_sample(s24), .in_sample_en(en24),
    .out_ready(rdy24), .out_tx(tx24), .out_done(done24)
  );

  sample2uart_tx #(.BPS(12), .CLK_FREQ(400), .BAUD(100)) dut12 (
    .in_clk(clk), .in_rst(rst), .in_sample(s12), .in_sample_en(en12),
    .out_ready(rdy12), .out_tx(tx12), .out_done(done12)
  );

  task automatic chk(input string tag, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", tag, got, want, $time);
    end
  endtask

  // Expected line level per cycle: per byte (MSB byte first) start, 8 data bits LSB first, stop.
  task automatic build_exp(input logic [23:0] s, input int nb);
    logic [7:0] b;
    exp_q.delete();
    for (int j = nb - 1; j >= 0; j--) begin
      b = s[8*j +: 8];
      repeat (CPB) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (CPB) exp_q.push_back(b[i]);
      repeat (CPB) exp_q.push_back(1'b1);
    end
  endtask

  task automatic drive(input bit use12, input logic en, input logic [23:0] s);
    if (use12) begin
      en12 = en;
      s12  = s[11:0];
    end else begin
      en24 = en;
      s24  = s;
    end
  endtask

  // Entered just after a falling edge; optionally leaves the next sample armed in the done cycle.
  task automatic xfer(input bit use12, input logic [23:0] s, input logic [23:0] s_alt,
                      input bit hold2, input bit chain, input logic [23:0] s_next);
    int len;
    logic tx, rdy, done;
    len = (use12 ? 2 : 3) * 10 * CPB;
    build_exp(s, use12 ? 2 : 3);
    drive(use12, 1'b1, s);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      tx   = use12 ? tx12 : tx24;
      rdy  = use12 ? rdy12 : rdy24;
      done = use12 ? done12 : done24;
      chk("line", tx, exp_q[k-1]);
      chk("busy_rdy", rdy, 1'b0);
      chk("busy_done", done, 1'b0);
      if (k == 1) drive(use12, hold2, s_alt);
      if (k == 2) drive(use12, 1'b0, s_alt);
    end
    @(negedge clk);
    chk("end_done", use12 ? done12 : done24, 1'b1);
    chk("end_rdy", use12 ? rdy12 : rdy24, 1'b1);
    chk("end_tx", use12 ? tx12 : tx24, 1'b1);
    if (chain) begin
      drive(use12, 1'b1, s_next);
    end else begin
      @(negedge clk);
      chk("after_done", use12 ? done12 : done24, 1'b0);
      chk("after_rdy", use12 ? rdy12 : rdy24, 1'b1);
      chk("after_tx", use12 ? tx12 : tx24, 1'b1);
    end
  endtask

  initial begin
    logic [23:0] r;
    rst = 1'b1; en24 = 1'b0; en12 = 1'b0; s24 = '0; s12 = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx24, 1'b1);
    chk("rst_rdy", rdy24, 1'b1);
    chk("rst_done", done24, 1'b0);
    chk("rst_tx12", tx12, 1'b1);
    chk("rst_rdy12", rdy12, 1'b1);
    rst = 1'b0;

    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("idle_tx", tx24, 1'b1);
      chk("idle_rdy", rdy24, 1'b1);
      chk("idle_done", done24, 1'b0);
    end

    xfer(1'b0, 24'hA53C0F, 24'hA53C0F, 1'b0, 1'b0, 24'h0);
    xfer(1'b0, 24'h111111, 24'h222222, 1'b1, 1'b0, 24'h0);
    xfer(1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 24'h000000);
    xfer(1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 24'h0);

    // Reset in the 5th data bit of the first (MSB) byte, whose level there is 0.
    build_exp(24'hA53C0F, 3);
    drive(1'b0, 1'b1, 24'hA53C0F);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      chk("pre_rst_line", tx24, exp_q[k-1]);
      if (k == 1) drive(1'b0, 1'b0, 24'hA53C0F);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx24, 1'b1);
    chk("mid_rst_rdy", rdy24, 1'b1);
    chk("mid_rst_done", done24, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_tx", tx24, 1'b1);
      chk("post_rst_done", done24, 1'b0);
      chk("post_rst_rdy", rdy24, 1'b1);
    end
    xfer(1'b0, 24'h800001, 24'h800001, 1'b0, 1'b0, 24'h0);

    xfer(1'b1, 24'h000ABC, 24'h000ABC, 1'b0, 1'b0, 24'h0);

    for (int n = 0; n < 4; n++) begin
      r = 24'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xfer(1'b0, r, 24'($urandom), n[0], 1'b0, 24'h0);
    end
    for (int n = 0; n < 2; n++) begin
      r = {12'h0, 12'($urandom)};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xfer(1'b1, r, r, 1'b0, 1'b0, 24'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
